// File: rtl/alarm_bank.sv
// Bank of BCD wall-clock alarm slots driving a single ring/snooze/idle controller.
// The lowest-numbered matching slot rings; snooze and ring timeouts count sec_tick pulses.
module alarm_bank #(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    localparam int IDXW            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sec_tick,
    input  logic [3:0]            hr_t,
    input  logic [3:0]            hr_o,
    input  logic [3:0]            min_t,
    input  logic [3:0]            min_o,
    input  logic [3:0]            sec_t,
    input  logic [3:0]            sec_o,
    input  logic                  wr_en,
    input  logic [IDXW-1:0]       wr_idx,
    input  logic [15:0]           wr_time,
    input  logic                  wr_arm,
    input  logic                  stop,
    input  logic                  snooze,
    output logic                  alarm_ring,
    output logic [IDXW-1:0]       ring_idx,
    output logic                  snoozing,
    output logic [NUM_ALARMS-1:0] armed_mask,
    output logic                  wr_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [15:0] RING_LIM   = 16'(RING_TIMEOUT_SEC);
    localparam logic [15:0] SNOOZE_LIM = 16'(SNOOZE_SEC);

    state_t                state;
    state_t                state_next;
    logic [15:0]           cnt;
    logic [15:0]           cnt_next;
    logic [15:0]           cnt_inc;
    logic [IDXW-1:0]       ring_idx_next;
    logic [15:0]           slot_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] armed;
    logic                  time_ok;
    logic                  wr_ok;
    logic                  slot_hit;
    logic                  trig;
    logic [IDXW-1:0]       win;
    logic [15:0]           cur_time;

    assign cur_time = {hr_t, hr_o, min_t, min_o};

    // Hours 00..23 and minutes 00..59 with every digit a legal BCD digit.
    always_comb begin
        time_ok = (wr_time[15:12] <= 4'd2) && (wr_time[11:8] <= 4'd9) &&
                  !((wr_time[15:12] == 4'd2) && (wr_time[11:8] > 4'd3)) &&
                  (wr_time[7:4] <= 4'd5) && (wr_time[3:0] <= 4'd9);
        wr_ok    = wr_en && time_ok && (32'(wr_idx) < NUM_ALARMS);
        slot_hit = wr_ok && (wr_idx == ring_idx);
    end

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        trig = 1'b0;
        win  = '0;
        if (sec_tick && (sec_t == 4'd0) && (sec_o == 4'd0)) begin
            for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
                if (armed[i] && (slot_time[i] == cur_time)) begin
                    trig = 1'b1;
                    win  = IDXW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) slot_time[i] <= '0;
            armed  <= '0;
            wr_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (wr_ok && (wr_idx == IDXW'(i))) begin
                    slot_time[i] <= wr_time;
                    armed[i]     <= wr_arm;
                end
            end
            wr_err <= wr_en && !wr_ok;
        end
    end

    assign cnt_inc = (sec_tick && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ring_idx <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ring_idx <= ring_idx_next;
        end
    end

    // Every state change clears the seconds counter.
    always_comb begin
        state_next    = state;
        cnt_next      = '0;
        ring_idx_next = ring_idx;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_next    = RING;
                    ring_idx_next = win;
                end
            end
            RING: begin
                if (slot_hit || stop)        state_next = IDLE;
                else if (snooze)             state_next = SNOOZE;
                else if (cnt_inc >= RING_LIM) state_next = IDLE;
                else                         cnt_next   = cnt_inc;
            end
            SNOOZE: begin
                if (slot_hit || stop)           state_next = IDLE;
                else if (cnt_inc >= SNOOZE_LIM) state_next = RING;
                else                            cnt_next   = cnt_inc;
            end
            default: state_next = IDLE;
        endcase
    end

    assign alarm_ring = (state == RING);
    assign snoozing   = (state == SNOOZE);
    assign armed_mask = armed;

endmodule

// File: doc/alarm_bank.md
ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 The block SHALL have parameter NUM_ALARMS, default 4, meaning number of independent alarm slots (legal 1..16).
REQ-002 The block SHALL have parameter SNOOZE_SEC, default 300, meaning snooze length in sec_tick pulses (legal 1..65535).
REQ-003 The block SHALL have parameter RING_TIMEOUT_SEC, default 60, meaning sec_tick pulses of ringing before auto-silence (legal 1..65535).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- sec_tick  in  1  one-cycle strobe per elapsed second
- hr_t, hr_o, min_t, min_o, sec_t, sec_o  in  4 each  current time, BCD tens/ones
- wr_en  in  1  slot write strobe
- wr_idx  in  IDXW = max(1, ceil(log2(NUM_ALARMS)))  slot to write
- wr_time  in  16  BCD {hr_t, hr_o, min_t, min_o}
- wr_arm  in  1  arm (1) or disarm (0) the written slot
- stop  in  1  stop pulse
- snooze  in  1  snooze pulse
- alarm_ring  out  1  ringing indicator
- ring_idx  out  IDXW  index of ringing/snoozed slot
- snoozing  out  1  snooze in progress
- armed_mask  out  NUM_ALARMS  per-slot armed flag
- wr_err  out  1  one-cycle pulse: write rejected

Function
REQ-005 Each slot SHALL hold a 16-bit BCD time and an armed bit; armed_mask[i] SHALL reflect slot i's armed bit.
REQ-006 A write SHALL be accepted when wr_en=1, wr_idx<NUM_ALARMS, hour<=23, minute<=59, every digit<=9; slot contents update at that clock edge.
REQ-007 A write failing REQ-006 SHALL leave all slots unchanged and pulse wr_err high for exactly the next cycle.
REQ-008 FSM states SHALL be IDLE, RING, SNOOZE; reset state IDLE.
REQ-009 A trigger SHALL occur in a cycle with sec_tick=1, sec_t=0, sec_o=0, and an armed slot whose time equals {hr_t,hr_o,min_t,min_o}.
REQ-010 On simultaneous matching slots, the lowest index SHALL win.
REQ-011 IDLE + trigger SHALL move to RING on that edge; alarm_ring=1 and ring_idx=winner from the next cycle (one-cycle latency).
REQ-012 Triggers in RING or SNOOZE SHALL be ignored and not queued.
REQ-013 In RING a seconds counter SHALL clear on entry and count sec_tick; at RING_TIMEOUT_SEC ticks the FSM SHALL go to IDLE (auto-silence).
REQ-014 In RING, stop=1 SHALL go to IDLE; snooze=1 with stop=0 SHALL go to SNOOZE; stop SHALL win when both are high.
REQ-015 In SNOOZE, alarm_ring SHALL be 0 and snoozing 1; the counter SHALL clear on entry and count sec_tick; at SNOOZE_SEC ticks the FSM SHALL return to RING with the same ring_idx and a fresh timeout.
REQ-016 In SNOOZE, stop SHALL go to IDLE; snooze SHALL be ignored.
REQ-017 stop/snooze in IDLE SHALL have no effect.
REQ-018 Disarming or rewriting the slot at ring_idx SHALL go to IDLE on the same edge.
REQ-019 Counters SHALL be 16 bits and saturate, never wrap.
REQ-020 ring_idx SHALL hold its last value in IDLE.

Reset
REQ-021 Asserting reset_n=0 SHALL immediately, independent of clk, clear every slot to 00:00 disarmed and set state IDLE, alarm_ring=0, snoozing=0, ring_idx=0, armed_mask=0, wr_err=0, counters=0.
REQ-022 Reset during RING or SNOOZE SHALL abort the ring with no resumption after release.

Verification
REQ-023 Arm slot 1 at 06:30; drive 06:29:59 then tick to 06:30:00 -> alarm_ring=1, ring_idx=1 the cycle after the tick.
REQ-024 Arm slots 2 and 0 at 07:00; reach 07:00:00 -> ring_idx=0; while ringing, slot 3 matching 07:01 -> ignored.
REQ-025 Default params: ring, then snooze -> alarm_ring=0, snoozing=1; after 300 ticks -> alarm_ring=1, same ring_idx; 60 further ticks -> IDLE.
REQ-026 Write 24:00 and 12:7A -> wr_err one cycle each, armed_mask unchanged.
REQ-027 stop and snooze in the same cycle while ringing -> IDLE, snoozing stays 0.
REQ-028 reset_n low mid-SNOOZE between clock edges -> all outputs 0 at once; no ring after release.
